// File: rtl/modexp_wb_ctrl.sv
// Wishbone B4 classic slave for the modexp core: register file, start/completion
// sequencing, coherent 64-bit cycle counter and a sticky, maskable completion interrupt.
`timescale 1ns/1ps
module modexp_wb_ctrl #(
  parameter int unsigned AW           = 32,
  parameter int unsigned ADW          = 8,
  parameter int unsigned DEF_LEN      = 128,
  parameter logic [31:0] CORE_VERSION = 32'h302e3630
) (
  input  logic           wb_clk_i,
  input  logic           reset_n,
  input  logic [AW-1:0]  wb_adr_i,
  input  logic [31:0]    wb_dat_i,
  input  logic [3:0]     wb_sel_i,
  input  logic           wb_cyc_i,
  input  logic           wb_stb_i,
  input  logic           wb_we_i,
  output logic [31:0]    wb_dat_o,
  output logic           wb_ack_o,
  output logic           wb_err_o,
  output logic           int_o,
  output logic           core_start,
  input  logic           core_ready,
  output logic [ADW-1:0] core_mod_len,
  output logic [ADW-1:0] core_exp_len,
  output logic [1:0]     core_mem_sel,
  output logic           core_mem_cs,
  output logic           core_mem_wr,
  output logic           core_mem_rst,
  output logic [31:0]    core_mem_wdata,
  input  logic [31:0]    core_mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 64;

  localparam logic [DW-1:0] NAME0 = 32'h6d6f6465;
  localparam logic [DW-1:0] NAME1 = 32'h78702020;

  localparam logic [7:0] A_NAME0   = 8'h00;
  localparam logic [7:0] A_NAME1   = 8'h01;
  localparam logic [7:0] A_VERSION = 8'h02;
  localparam logic [7:0] A_CTRL    = 8'h08;
  localparam logic [7:0] A_STATUS  = 8'h09;
  localparam logic [7:0] A_IRQ_EN  = 8'h0A;
  localparam logic [7:0] A_IRQ_CLR = 8'h0B;
  localparam logic [7:0] A_CYC_HI  = 8'h10;
  localparam logic [7:0] A_CYC_LO  = 8'h11;
  localparam logic [7:0] A_MOD_LEN = 8'h20;
  localparam logic [7:0] A_EXP_LEN = 8'h21;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SYNC, ST_BUSY} state_t;

  state_t          state, state_d;
  logic            start_d;
  logic            done_set_c;
  logic            busy;
  logic            done;
  logic            irq_en;
  logic [CW-1:0]   count;
  logic [DW-1:0]   cyc_shadow;

  logic [7:0]      addr;
  logic            req_c, bad_c, ok_c, err_c, wr_ok_c, rd_ok_c;
  logic            mapped, ro, guarded, is_len, is_data, is_ptr;
  logic [DW-1:0]   rd_data;
  logic [2:0]      mem_idx;
  logic            start_c, clr_c;
  logic            unused_adr;

  assign addr       = wb_adr_i[7:0];
  assign unused_adr = ^wb_adr_i[AW-1:8];
  assign busy       = (state != ST_IDLE);

  // Ack/err registers mask the request so a held strobe is not a second access.
  assign req_c = reset_n & wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  // Address decode and read mux.
  always_comb begin
    mapped  = 1'b1;
    ro      = 1'b0;
    guarded = 1'b0;
    is_len  = 1'b0;
    is_data = 1'b0;
    is_ptr  = 1'b0;
    rd_data = '0;
    case (addr)
      A_NAME0:   begin ro = 1'b1; rd_data = NAME0; end
      A_NAME1:   begin ro = 1'b1; rd_data = NAME1; end
      A_VERSION: begin ro = 1'b1; rd_data = CORE_VERSION; end
      A_CTRL:    begin guarded = 1'b1; rd_data = {31'b0, busy}; end
      A_STATUS:  begin ro = 1'b1; rd_data = {29'b0, int_o, done, ~busy}; end
      A_IRQ_EN:  rd_data = {31'b0, irq_en};
      A_IRQ_CLR: rd_data = '0;
      A_CYC_HI:  begin ro = 1'b1; rd_data = cyc_shadow; end
      A_CYC_LO:  begin ro = 1'b1; rd_data = count[31:0]; end
      A_MOD_LEN: begin guarded = 1'b1; is_len = 1'b1; rd_data = DW'(core_mod_len); end
      A_EXP_LEN: begin guarded = 1'b1; is_len = 1'b1; rd_data = DW'(core_exp_len); end
      8'h30, 8'h40, 8'h50, 8'h60: begin guarded = 1'b1; is_ptr = 1'b1; end
      8'h31, 8'h41, 8'h51: begin guarded = 1'b1; is_data = 1'b1; rd_data = core_mem_rdata; end
      8'h61:     begin guarded = 1'b1; ro = 1'b1; is_data = 1'b1; rd_data = core_mem_rdata; end
      default:   mapped = 1'b0;
    endcase
  end

  assign bad_c   = ~mapped |
                   (wb_we_i & (ro | (wb_sel_i != 4'hF) |
                               (is_len & (wb_dat_i[ADW-1:0] == '0)) |
                               (guarded & busy)));
  assign err_c   = req_c & bad_c;
  assign ok_c    = req_c & ~bad_c;
  assign wr_ok_c = ok_c & wb_we_i;
  assign rd_ok_c = ok_c & ~wb_we_i;
  assign start_c = wr_ok_c & (addr == A_CTRL) & wb_dat_i[0];
  assign clr_c   = wr_ok_c & (addr == A_IRQ_CLR) & wb_dat_i[0];

  // Operand-memory port: strobes are single-cycle, qualified by the request.
  assign mem_idx        = addr[6:4] - 3'd3;
  assign core_mem_sel   = (reset_n & (is_data | is_ptr)) ? mem_idx[1:0] : 2'd0;
  assign core_mem_cs    = ok_c & is_data;
  assign core_mem_wr    = wr_ok_c & is_data;
  assign core_mem_rst   = wr_ok_c & is_ptr;
  assign core_mem_wdata = reset_n ? wb_dat_i : '0;

  // Start/completion sequencing.
  always_comb begin
    state_d    = state;
    start_d    = 1'b0;
    done_set_c = 1'b0;
    case (state)
      ST_IDLE: if (start_c) state_d = ST_ARM;
      ST_ARM:  begin start_d = 1'b1; state_d = ST_SYNC; end
      ST_SYNC: if (!core_ready) state_d = ST_BUSY;
      ST_BUSY: if (core_ready) begin done_set_c = 1'b1; state_d = ST_IDLE; end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      core_start <= 1'b0;
    end else begin
      state      <= state_d;
      core_start <= start_d;
    end
  end

  // Bus response and register file.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= '0;
      core_mod_len <= ADW'(DEF_LEN);
      core_exp_len <= ADW'(DEF_LEN);
      irq_en       <= 1'b0;
      done         <= 1'b0;
      int_o        <= 1'b0;
      cyc_shadow   <= '0;
    end else begin
      wb_ack_o <= ok_c;
      wb_err_o <= err_c;
      if (rd_ok_c)
        wb_dat_o <= rd_data;
      else if (req_c && wb_we_i)
        wb_dat_o <= '0;
      if (wr_ok_c && addr == A_MOD_LEN) core_mod_len <= wb_dat_i[ADW-1:0];
      if (wr_ok_c && addr == A_EXP_LEN) core_exp_len <= wb_dat_i[ADW-1:0];
      if (wr_ok_c && addr == A_IRQ_EN)  irq_en <= wb_dat_i[0];
      // Completion wins over a simultaneous clear.
      if (done_set_c)
        done <= 1'b1;
      else if (clr_c)
        done <= 1'b0;
      int_o <= done & irq_en;
      if (rd_ok_c && addr == A_CYC_LO) cyc_shadow <= count[CW-1:32];
    end
  end

  // Saturating cycle counter, cleared when a new operation is armed.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (state == ST_ARM)
      count <= '0;
    else if ((state == ST_SYNC || state == ST_BUSY) && count != '1)
      count <= count + CW'(1);
  end

endmodule

// File: doc/modexp_wb_ctrl.md
# modexp_wb_ctrl

Parametrised Wishbone B4 classic slave that fronts a modular-exponentiation core in the RSA subsystem. It succeeds the fixed, always-acking RSA wrapper. New behaviour:
- registered single-cycle ack and error signalling
- a start/completion state machine
- a self-timed, coherently readable 64-bit cycle counter
- a maskable sticky completion interrupt

The core attaches through a generic operand-memory port, and the integrator muxes `core_mem_rdata` by `core_mem_sel`.

## Interface
- `AW`, 32, Wishbone address width; only `wb_adr_i[7:0]` is decoded.
- `ADW`, 8, width of the modulus/exponent length registers, in 32-bit words.
- `DEF_LEN`, 128, reset value of both length registers.
- `CORE_VERSION`, 32'h302e3630, value read at 0x02 ("0.60").

Ports:
- `wb_clk_i` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wb_adr_i` in AW, `wb_dat_i` in 32, `wb_sel_i` in 4, `wb_cyc_i` in 1, `wb_stb_i` in 1, `wb_we_i` in 1: Wishbone request.
- `wb_dat_o` out 32, `wb_ack_o` out 1, `wb_err_o` out 1: Wishbone response, all registered.
- `int_o` out 1: registered completion interrupt.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_ready` in 1: core idle/done level.
- `core_mod_len` out ADW, `core_exp_len` out ADW: length registers.
- `core_mem_sel` out 2: selects the memory (0 modulus, 1 exponent, 2 message, 3 result).
- `core_mem_cs`, `core_mem_wr`, `core_mem_rst` out 1: memory strobes.
- `core_mem_wdata` out 32 (`wb_dat_i` passthrough); `core_mem_rdata` in 32.

## Operation
**Request qualification**
- `req = reset_n & wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`.
- Every side effect (register write, memory strobe, read capture) happens only in the `req` cycle.

**Register map (write W, read R)**
- 0x00 / 0x01 NAME0 / NAME1 ("mode" / "xp  ") R; 0x02 VERSION R.
- 0x08 CTRL: W bit0 = start; R bit0 = busy.
- 0x09 STATUS R: bit0 idle, bit1 done (sticky), bit2 int_o.
- 0x0A IRQ_EN R/W, bit0.
- 0x0B IRQ_CLR W: writing 1 to bit0 clears done.
- 0x10 CYCLES_HIGH R: returns the shadow latched by the last CYCLES_LOW read.
- 0x11 CYCLES_LOW R: returns `count[31:0]` and latches `count[63:32]` into the shadow the same cycle.
- 0x20 / 0x21 MODULUS / EXPONENT length R/W, `wb_dat_i[ADW-1:0]`.
- 0x30 / 0x40 / 0x50 / 0x60 pointer reset W: `core_mem_rst`=1 with the matching `core_mem_sel`.
- 0x31 / 0x41 / 0x51 data R/W; 0x61 result data R only.
  - Writes: `core_mem_cs`=`core_mem_wr`=1.
  - Reads: `core_mem_cs`=1, `wb_dat_o` <= `core_mem_rdata`.

**Error rules**
- `wb_err_o` is raised instead of ack for any of these, and the access has no side effect:
  - unmapped address
  - write to a read-only address
  - write with `wb_sel_i` != 4'hF
  - length write of 0
  - any write to 0x08 or 0x20–0x61 while busy
- Reads while busy are allowed.

**FSM: IDLE → ARM → SYNC → BUSY → IDLE**
- IDLE: a valid start write moves to ARM. A CTRL write with bit0=0 is acked and does nothing.
- ARM: `core_start`=1 for exactly one cycle; counter is cleared to 0; go to SYNC.
- SYNC: wait for `core_ready`=0, then go to BUSY.
- BUSY: when `core_ready`=1, latch completion, set done, go to IDLE.
- Counter increments every cycle in SYNC and BUSY, saturating at 2^64−1.
- busy = (state != IDLE).

**Interrupt**
- `int_o` <= done & IRQ_EN.
- Completion in the same cycle as an IRQ_CLR write leaves done set (set wins).

## Timing
- Request sampled in cycle N → `wb_ack_o` or `wb_err_o` high in N+1 for exactly one cycle, with `wb_dat_o` valid in N+1.
- `wb_dat_o` holds until the next read and is 0 on writes.
- Memory strobes are combinational from `req` and the decode: one-cycle pulse in cycle N.
- A master holding stb through the ack cycle creates no second access.
- Start write in N → `core_start` in N+2; STATUS.idle reads 0 from N+2.
- Completion seen in N → done and idle in N+1, `int_o` in N+2.
- Reset mid-operation:
  - FSM returns to IDLE; counter, shadow, done and IRQ_EN clear.
  - Lengths return to DEF_LEN.
  - All outputs go to 0 (the strobes are gated by `reset_n`), including `wb_ack_o`, `wb_err_o`, `wb_dat_o`, `int_o` and `core_start`.

## Test plan
- Reset, then read 0x00/0x01/0x02/0x20 → 6d6f6465 / 78702020 / 302e3630 / 00000080. Each ack is exactly one cycle wide, with stb held for 3 cycles.
- Write modulus length 0x40; write 0x30 then four words to 0x31; reset the pointer; read back four words → same data, one `core_mem_cs` pulse per access. Write of 0 to 0x20 → err, length stays 0x40.
- Start with the core model's ready dropping 1 cycle after start and rising 100 cycles later → single `core_start` pulse. Read 0x11 then 0x10 → count 101, high 0. Done=1; with IRQ_EN=1, `int_o`=1.
- While busy: write 0x31 → err, no `core_mem_cs`. Write 0x08 → err, no second `core_start`. Read 0x09 → idle bit 0.
- Write 0x61, read 0x99, write with `wb_sel_i`=4'h3 → `wb_err_o` each time, no side effects.
- IRQ_CLR write in the completion cycle → done stays 1. A later clear drops `int_o` 2 cycles after the request. Asserting `reset_n`=0 mid-BUSY → all outputs 0, lengths back to 0x80.
